// File: rtl/serial_host_master_if.sv
// Request/response port bundle for serial_host_master.
// The requester drives cmd_* and reads rsp_*; the serial_host_master block itself
// sits on the slave modport.
interface serial_host_master_if #(
  parameter int PERIPH_ADDR_WIDTH = 4
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_rw;
  logic [PERIPH_ADDR_WIDTH-1:0] cmd_periph_addr;
  logic [7:0]                   cmd_reg_addr;
  logic [7:0]                   cmd_wdata;
  logic                         rsp_valid;
  logic [7:0]                   rsp_rdata;
  logic                         rsp_timeout;
  logic                         busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_periph_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_periph_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );
endinterface

// File: rtl/serial_host_master.sv
// Host-side initiator for the serial_fpga command protocol.
// Serializes one register read/write request as 8N1 bytes on txd and, for reads,
// waits (with a timeout) for the one-byte reply on rxd.
module serial_host_master #(
  parameter int CLK_FREQUENCY     = 50_000_000,
  parameter int BAUD              = 115_200,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES    = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_host_master_if.slave  bus,
  input  logic                 rxd,
  output logic                 txd
);

  localparam int DIV   = CLK_FREQUENCY / BAUD;
  localparam int HALF  = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_CMD, S_TX_ADDR, S_TX_DATA, S_RX_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  // Frame bit idx of a byte: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [3:0] j;
    j = idx - 4'd1;
    if (idx == 4'd0)      return 1'b0;
    else if (idx >= 4'd9) return 1'b1;
    else                  return b[j[2:0]];
  endfunction

  // Transmit / command FSM state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic             txd_q, txd_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  // Registered request
  logic             rw_q;
  logic [7:0]       byte0_q, reg_q, wdata_q;
  logic [6:0]       pa_ext;
  logic [7:0]       cur_byte;
  logic             accept;

  // Timeout
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit_q;

  // Receiver
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_done_q, rx_done_d;

  assign accept          = (state_q == S_IDLE) && bus.cmd_valid;
  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rsp_valid   = (state_q == S_DONE);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign txd             = txd_q;

  // Zero-extend the peripheral address into the 7-bit field of byte0.
  always_comb begin
    pa_ext = '0;
    pa_ext[PERIPH_ADDR_WIDTH-1:0] = bus.cmd_periph_addr;
  end

  // Capture the request fields at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= bus.cmd_rw;
      byte0_q <= {bus.cmd_rw, pa_ext};
      reg_q   <= bus.cmd_reg_addr;
      wdata_q <= bus.cmd_wdata;
    end
  end

  // Byte currently on the wire, selected by which TX state is active.
  always_comb begin
    cur_byte = wdata_q;
    if (state_q == S_TX_CMD)       cur_byte = byte0_q;
    else if (state_q == S_TX_ADDR) cur_byte = reg_q;
  end

  // Command FSM state register, bit timing and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      txd_q         <= 1'b1;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      txd_q         <= txd_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Command FSM next state: back-to-back bytes, reply wait and completion.
  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    txd_d         = txd_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (bus.cmd_valid) begin
          state_d = S_TX_CMD;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end
      S_TX_CMD, S_TX_ADDR, S_TX_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            // Stop bit done: next byte starts with its start bit immediately.
            bit_d = '0;
            if (state_q == S_TX_CMD) begin
              state_d = S_TX_ADDR;
              txd_d   = 1'b0;
            end else if (state_q == S_TX_ADDR && !rw_q) begin
              state_d = S_TX_DATA;
              txd_d   = 1'b0;
            end else if (state_q == S_TX_ADDR) begin
              state_d = S_RX_WAIT;
              txd_d   = 1'b1;
            end else begin
              state_d       = S_DONE;
              txd_d         = 1'b1;
              rsp_rdata_d   = '0;
              rsp_timeout_d = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            txd_d = frame_bit(cur_byte, bit_q + 4'd1);
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_RX_WAIT: begin
        txd_d = 1'b1;
        // A byte completing on the timeout cycle takes priority.
        if (rx_done_q) begin
          state_d       = S_DONE;
          rsp_rdata_d   = rx_byte_q;
          rsp_timeout_d = 1'b0;
        end else if (tmo_hit_q) begin
          state_d       = S_DONE;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Reply timeout: counts from zero on RX_WAIT entry, flags the limit one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_hit_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_RX_WAIT) ? tmo_cnt_q + 1'b1 : '0;
      tmo_hit_q <= (state_q == S_RX_WAIT) && (tmo_cnt_q == TMO_LAST);
    end
  end

  // Two-flop synchronizer on rxd plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receiver FSM state register and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // Receiver shift and holding registers.
  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    rx_byte_q  <= rx_byte_d;
  end

  // Receiver next state: start re-check at half bit, centre sampling, stop check.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rx_s2_q) begin
            rx_byte_d = rx_shift_q;
            rx_done_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_host_master.sv
// Directed bench for serial_host_master at DIV=10, TIMEOUT_CYCLES=500.
module tb_serial_host_master;

  localparam int DIV = 10;

  logic clk;
  logic reset;
  logic rxd;
  logic txd;
  int   vectors;
  int   miscompares;

  serial_host_master_if #(.PERIPH_ADDR_WIDTH(4)) bus ();

  serial_host_master #(
    .CLK_FREQUENCY    (1_000_000),
    .BAUD             (100_000),
    .PERIPH_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES   (500)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .rxd  (rxd),
    .txd  (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Present a request and wait (bounded) for the acceptance edge; cycle 0 = that edge.
  // Fields are scrambled right after acceptance to show they were registered.
  task automatic issue(input logic rw, input logic [3:0] pa, input logic [7:0] ra,
                       input logic [7:0] wd, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_rw = rw; bus.cmd_periph_addr = pa; bus.cmd_reg_addr = ra;
    bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    ok = (bus.cmd_ready === 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_rw = ~rw; bus.cmd_periph_addr = ~pa;
    bus.cmd_reg_addr = ~ra; bus.cmd_wdata = ~wd;
  endtask

  // Sample txd at the first and last cycle of every bit slot after acceptance.
  task automatic capture_tx(input int nbytes, inout int cyc, output logic [7:0] b0,
                            output logic [7:0] b1, output logic [7:0] b2, output int ferr);
    logic [9:0] fr;
    logic s0;
    ferr = 0; b0 = '0; b1 = '0; b2 = '0; fr = '0;
    for (int k = 0; k < nbytes; k++) begin
      for (int b = 0; b < 10; b++) begin
        while (cyc < 1 + (k * 10 + b) * DIV) begin @(negedge clk); cyc++; end
        s0 = txd;
        while (cyc < (k * 10 + b + 1) * DIV) begin @(negedge clk); cyc++; end
        if (s0 !== txd) ferr++;
        fr[b] = txd;
      end
      if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ferr++;
      if (k == 0) b0 = fr[8:1];
      else if (k == 1) b1 = fr[8:1];
      else b2 = fr[8:1];
    end
  endtask

  // Wait (bounded) for rsp_valid; report its cycle, payload, width and ready behaviour.
  task automatic wait_rsp(input int limit, inout int cyc, output bit got, output int at,
                          output logic [7:0] d, output logic to, output int width,
                          output logic rdy_after, output int early_rdy);
    got = 1'b0; at = -1; d = 'x; to = 'x; width = 0; rdy_after = 'x; early_rdy = 0;
    while (!got && cyc < limit) begin
      @(negedge clk); cyc++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1; at = cyc; d = bus.rsp_rdata; to = bus.rsp_timeout;
      end else if (bus.cmd_ready !== 1'b0) begin
        early_rdy++;
      end
    end
    if (got) begin
      @(negedge clk); cyc++;
      width = (bus.rsp_valid === 1'b1) ? 2 : 1;
      rdy_after = bus.cmd_ready;
    end
  endtask

  // Drive one 8N1 byte on rxd starting at the current negedge.
  task automatic uart_send(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({txd, bus.cmd_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_hold: txd,ready=%b required 11", {txd, bus.cmd_ready});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({txd, bus.cmd_ready, bus.rsp_valid, bus.busy} !== 4'b1100) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: txd,ready,rsp_valid,busy=%b required 1100", i,
                 {txd, bus.cmd_ready, bus.rsp_valid, bus.busy});
      end
    end
    vectors++;
    if ({bus.rsp_rdata, bus.rsp_timeout} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_rsp: rdata=%h timeout=%b required 00/0", bus.rsp_rdata, bus.rsp_timeout);
    end
  endtask

  task automatic test_write();
    bit ok, got; int cyc, at, width, ferr, early; logic [7:0] b0, b1, b2, d; logic to, ra;
    issue(1'b0, 4'd3, 8'h12, 8'hA5, ok);
    cyc = 0;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wr_accept: accepted=%b required 1", ok); end
    capture_tx(3, cyc, b0, b1, b2, ferr);
    vectors++;
    if ({b0, b1, b2} !== 24'h0312A5) begin
      miscompares++; $display("FAIL wr_bytes: got %h required 0312a5", {b0, b1, b2});
    end
    vectors++;
    if (ferr !== 0) begin miscompares++; $display("FAIL wr_framing: %0d bad slots required 0", ferr); end
    wait_rsp(1000, cyc, got, at, d, to, width, ra, early);
    vectors++;
    if (at !== 301) begin miscompares++; $display("FAIL wr_rsp_cycle: got T+%0d required T+301", at); end
    vectors++;
    if ({width, d, to} !== {32'd1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_rsp: width=%0d rdata=%h timeout=%b required 1/00/0", width, d, to);
    end
    vectors++;
    if ({ra, early} !== {1'b1, 32'd0}) begin
      miscompares++;
      $display("FAIL wr_ready: after=%b early=%0d required 1/0", ra, early);
    end
  endtask

  task automatic test_read_reply();
    bit ok, got; int cyc, at, width, ferr, early; logic [7:0] b0, b1, b2, d; logic to, ra;
    issue(1'b1, 4'd5, 8'h40, 8'hEE, ok);
    cyc = 0;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL rd_accept: accepted=%b required 1", ok); end
    capture_tx(2, cyc, b0, b1, b2, ferr);
    vectors++;
    if ({b0, b1, ferr} !== {8'h85, 8'h40, 32'd0}) begin
      miscompares++;
      $display("FAIL rd_bytes: got %h %h ferr=%0d required 85 40 0", b0, b1, ferr);
    end
    while (cyc < 250) begin @(negedge clk); cyc++; end
    fork
      uart_send(8'h3C);
      wait_rsp(1000, cyc, got, at, d, to, width, ra, early);
    join
    vectors++;
    if ({got, d, to, width} !== {1'b1, 8'h3C, 1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL rd_reply: got=%b rdata=%h timeout=%b width=%0d required 1/3c/0/1", got, d, to, width);
    end
    vectors++;
    if (early !== 0) begin miscompares++; $display("FAIL rd_ready_early: %0d cycles required 0", early); end
  endtask

  task automatic test_read_timeout();
    bit ok, got; int cyc, at, width, ferr, early; logic [7:0] b0, b1, b2, d; logic to, ra;
    issue(1'b1, 4'd5, 8'h41, 8'h00, ok);
    cyc = 0;
    capture_tx(2, cyc, b0, b1, b2, ferr);
    vectors++;
    if ({ok, b0, b1, ferr} !== {1'b1, 8'h85, 8'h41, 32'd0}) begin
      miscompares++;
      $display("FAIL to_bytes: ok=%b %h %h ferr=%0d required 1 85 41 0", ok, b0, b1, ferr);
    end
    wait_rsp(900, cyc, got, at, d, to, width, ra, early);
    vectors++;
    if (at !== 702) begin miscompares++; $display("FAIL to_cycle: got T+%0d required T+702", at); end
    vectors++;
    if ({d, to, width, ra} !== {8'h00, 1'b1, 32'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL to_rsp: rdata=%h timeout=%b width=%0d ready=%b required 00/1/1/1", d, to, width, ra);
    end
  endtask

  task automatic test_noise();
    bit got; int cyc, at, width, ferr, early; logic [7:0] b0, b1, b2, d; logic to, ra;
    @(negedge clk);
    bus.cmd_rw = 1'b1; bus.cmd_periph_addr = 4'd2; bus.cmd_reg_addr = 8'h10;
    bus.cmd_wdata = 8'h00; bus.cmd_valid = 1'b1;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL nz_idle: ready=%b required 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    cyc = 0;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    uart_send(8'h77);
    cyc += 10 * DIV;
    vectors++;
    if (bus.cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL nz_busy: ready=%b required 0", bus.cmd_ready);
    end
    while (cyc < 230) begin @(negedge clk); cyc++; end
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    cyc += 3;
    rxd = 1'b1;
    while (cyc < 260) begin @(negedge clk); cyc++; end
    fork
      uart_send(8'h99);
      wait_rsp(1200, cyc, got, at, d, to, width, ra, early);
    join
    vectors++;
    if ({got, d, to} !== {1'b1, 8'h99, 1'b0}) begin
      miscompares++;
      $display("FAIL nz_reply: got=%b rdata=%h timeout=%b required 1/99/0", got, d, to);
    end
    vectors++;
    if ({early, width, ra} !== {32'd0, 32'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL nz_handshake: early=%0d width=%0d ready_after=%b required 0/1/1", early, width, ra);
    end
    // cmd_valid is still high: the coming edge accepts the second request.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    capture_tx(2, cyc, b0, b1, b2, ferr);
    vectors++;
    if ({b0, b1, ferr} !== {8'h82, 8'h10, 32'd0}) begin
      miscompares++;
      $display("FAIL nz_second_bytes: got %h %h ferr=%0d required 82 10 0", b0, b1, ferr);
    end
    while (cyc < 210) begin @(negedge clk); cyc++; end
    fork
      uart_send(8'h5A);
      wait_rsp(1000, cyc, got, at, d, to, width, ra, early);
    join
    vectors++;
    if ({got, d, to} !== {1'b1, 8'h5A, 1'b0}) begin
      miscompares++;
      $display("FAIL nz_second_reply: got=%b rdata=%h timeout=%b required 1/5a/0", got, d, to);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok, got; int cyc, at, width, ferr, early, stray_rsp, stray_txd;
    logic [7:0] b0, b1, b2, d; logic to, ra;
    issue(1'b0, 4'd6, 8'hC3, 8'h11, ok);
    cyc = 0;
    while (cyc < 145) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({txd, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL mr_after_reset: txd=%b ready=%b rsp_valid=%b rdata=%h required 1/1/0/00",
               txd, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata);
    end
    reset = 1'b0;
    stray_rsp = 0; stray_txd = 0;
    for (int i = 0; i < 350; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) stray_rsp++;
      if (txd !== 1'b1) stray_txd++;
    end
    vectors++;
    if ({stray_rsp, stray_txd} !== 64'd0) begin
      miscompares++;
      $display("FAIL mr_quiet: rsp_valid cycles=%0d txd low cycles=%0d required 0/0", stray_rsp, stray_txd);
    end
    issue(1'b0, 4'd1, 8'h22, 8'h5A, ok);
    cyc = 0;
    capture_tx(3, cyc, b0, b1, b2, ferr);
    vectors++;
    if ({ok, b0, b1, b2, ferr} !== {1'b1, 24'h01225A, 32'd0}) begin
      miscompares++;
      $display("FAIL mr_new_bytes: ok=%b %h %h %h ferr=%0d required 1 01 22 5a 0", ok, b0, b1, b2, ferr);
    end
    wait_rsp(1000, cyc, got, at, d, to, width, ra, early);
    vectors++;
    if ({at, d, to} !== {32'd301, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL mr_new_rsp: cycle=T+%0d rdata=%h timeout=%b required T+301/00/0", at, d, to);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    rxd = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw = 1'b0;
    bus.cmd_periph_addr = '0;
    bus.cmd_reg_addr = '0;
    bus.cmd_wdata = '0;
    test_reset();
    test_write();
    test_read_reply();
    test_read_timeout();
    test_noise();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_host_master.md
# serial_host_master

Host-side initiator for the serial_fpga command protocol: accepts one register read or write request on a valid/ready port, serializes it as UART command bytes on `txd`, and for reads captures the one-byte reply from `rxd`. It sits at the far end of the serial link from serial_fpga. It is used in loopback/self-test builds to drive a serial_fpga + hba_reg_bank design without a PC. It contains its own 8N1 transmitter, receiver and a timeout.

## Interface
- `CLK_FREQUENCY`, 50_000_000: clock rate in Hz.
- `BAUD`, 115_200: line rate; bit period `DIV = CLK_FREQUENCY/BAUD`, truncated (434 at defaults).
- `PERIPH_ADDR_WIDTH`, 4: peripheral address width; must be ≤ 7.
- `TIMEOUT_CYCLES`, 1_000_000: read-reply wait limit in clocks.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: block idle, request accepted when `cmd_valid & cmd_ready`.
- `cmd_rw` in 1: 1 = read, 0 = write.
- `cmd_periph_addr` in PERIPH_ADDR_WIDTH: target peripheral.
- `cmd_reg_addr` in 8: register address.
- `cmd_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 8: read data; 0 for writes and timeouts.
- `rsp_timeout` out 1: qualifies `rsp_valid`; 1 = no reply within limit.
- `busy` out 1: equals `~cmd_ready`.
- `rxd` in 1: serial in, asynchronous.
- `txd` out 1: serial out, idle high.

## Operation
- Frame bytes: byte0 = `{cmd_rw, cmd_periph_addr zero-extended to 7 bits}`, byte1 = `cmd_reg_addr`, byte2 = `cmd_wdata`. Byte2 is sent for writes only.
- UART format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each DIV clocks.
- All request fields are registered at acceptance; later input changes are ignored.
- FSM states:
  - IDLE: `cmd_ready` = 1. On acceptance, go to TX_CMD.
  - TX_CMD: send byte0, then go to TX_ADDR.
  - TX_ADDR: send byte1. Then go to TX_DATA if a write, RX_WAIT if a read.
  - TX_DATA: send byte2, then go to DONE.
  - RX_WAIT: wait for one received byte or timeout, then go to DONE.
  - DONE: pulse `rsp_valid` for one cycle, return to IDLE.
- RX path:
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge starts reception. The start bit is re-checked at DIV/2 and the frame is aborted if it reads high.
  - Data bits are sampled at bit centres.
  - Stop bit sampled 0 = framing error: the byte is discarded and RX_WAIT keeps waiting.
- The receiver runs continuously. Bytes that complete outside RX_WAIT are discarded. Only the first good byte completing in RX_WAIT is used.
- Timeout counter clears on entry to RX_WAIT. When it reaches TIMEOUT_CYCLES−1 with no byte, DONE is reached with `rsp_timeout` = 1 and `rsp_rdata` = 0.
- If a byte completes on the same cycle the timeout fires, the byte wins (`rsp_timeout` = 0).
- Reset values, effective the cycle after reset is sampled:
  - `txd` = 1, `cmd_ready` = 1, `busy` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_timeout` = 0.
  - FSM in IDLE, all counters 0.
- Reset mid-frame abandons the frame immediately, with no stop-bit completion and no `rsp_valid`.

## Timing
- Acceptance at cycle T: `cmd_ready` = 0 from T+1, and the byte0 start bit drives `txd` from T+1.
- Each byte takes exactly 10·DIV clocks. Successive bytes are back-to-back with no idle gap.
- Write: last stop bit ends at T+30·DIV. `rsp_valid` is high at cycle T+30·DIV+1, then `cmd_ready` = 1 from T+30·DIV+2.
- Read:
  - RX_WAIT is entered at T+20·DIV+1.
  - `rsp_valid` is asserted 2 cycles after the stop-bit centre sample, i.e. 1 cycle into DONE.
  - On timeout, `rsp_valid` is asserted at T+20·DIV+1+TIMEOUT_CYCLES+1.
- `rsp_rdata` and `rsp_timeout` hold their values until the next `rsp_valid`.
- Minimum spacing between accepted requests: 30·DIV+2 clocks for writes.
- RX latency from the `rxd` pin adds 2 clocks of synchronizer delay.

## Test plan
All scenarios use CLK_FREQUENCY=1_000_000, BAUD=100_000 (DIV=10) and TIMEOUT_CYCLES=500.
- Reset check: hold `reset` for 3 cycles, release -> `txd`=1, `cmd_ready`=1, `rsp_valid`=0 every cycle.
- Write: write periph 3, reg 0x12, data 0xA5.
  - `txd` carries bytes 0x03, 0x12, 0xA5, each 100 clocks, back-to-back.
  - `rsp_valid` pulses exactly 1 cycle at T+301, with `rsp_timeout`=0 and `rsp_rdata`=0.
- Read with reply: read periph 5, reg 0x40; bench UART replies 0x3C 50 clocks after byte1 stops.
  - `txd` carries 0x85 then 0x40.
  - `rsp_valid` fires with `rsp_rdata`=0x3C and `rsp_timeout`=0.
- Read timeout: read with no reply -> `rsp_valid` at T+702 with `rsp_timeout`=1 and `rsp_rdata`=0.
- Noise and stray bytes:
  - Inject 0x77 on `rxd` during TX_CMD, then a 3-clock glitch low in RX_WAIT, then reply 0x99.
  - Required: `rsp_rdata`=0x99.
  - Hold `cmd_valid` high throughout: the second request is accepted only after `rsp_valid`.
- Reset mid-frame: assert `reset` during bit 4 of byte1 -> `txd`=1 the next cycle, no `rsp_valid`, and a new request is accepted afterwards with correct bytes.
